dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: 240-byte internal RAM plus one peripheral window with
// wait-state handshake, timeout abort and a sticky bus-error flag.
module dmem_responder #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [7:0] Addr,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       Valid,
  output logic       Stall,
  output logic       BusError,
  output logic       PeriphReq,
  output logic       PeriphWe,
  output logic [3:0] PeriphAddr,
  output logic [7:0] PeriphWData,
  input  logic [7:0] PeriphRData,
  input  logic       PeriphAck
);

  localparam int unsigned DW        = 8;
  localparam int unsigned CW        = 4;
  localparam int unsigned RAM_DEPTH = 240;

  typedef enum logic [1:0] {IDLE, RAM_RD, P_WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          berr_q, berr_d;
  logic          preq_q, preq_d;
  logic          pwe_q, pwe_d;
  logic [3:0]    paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ram_we_c;
  logic          req_c;
  logic          periph_c;
  logic          timeout_c;

  logic [DW-1:0] mem [RAM_DEPTH];

  assign req_c     = MemRead | MemWrite;
  assign periph_c  = (Addr[7:4] == 4'hF);
  assign timeout_c = (cnt_q == CW'(TIMEOUT - 1));

  // Stall is the only combinational output; it is forced low while in reset
  assign Stall = reset & (((state_q == IDLE) & req_c & periph_c) | (state_q == P_WAIT));

  assign DataOut     = dout_q;
  assign Valid       = valid_q;
  assign BusError    = berr_q;
  assign PeriphReq   = preq_q;
  assign PeriphWe    = pwe_q;
  assign PeriphAddr  = paddr_q;
  assign PeriphWData = pwdata_q;

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    berr_d   = berr_q;
    preq_d   = 1'b0;
    pwe_d    = pwe_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    ram_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (periph_c) begin
            paddr_d  = Addr[3:0];
            pwdata_d = DataIn;
            pwe_d    = MemWrite;
            cnt_d    = '0;
            preq_d   = 1'b1;
            state_d  = P_WAIT;
          end else if (MemWrite) begin
            ram_we_c = 1'b1;
          end else begin
            dout_d  = mem[Addr];
            valid_d = 1'b1;
            state_d = RAM_RD;
          end
        end
      end
      RAM_RD: state_d = IDLE;
      P_WAIT: begin
        cnt_d  = cnt_q + CW'(1);
        preq_d = 1'b1;
        // Ack wins over a coincident timeout
        if (PeriphAck) begin
          preq_d  = 1'b0;
          state_d = DONE;
          if (!pwe_q) begin
            dout_d  = PeriphRData;
            valid_d = 1'b1;
          end
        end else if (timeout_c) begin
          preq_d  = 1'b0;
          berr_d  = 1'b1;
          state_d = DONE;
          if (!pwe_q) begin
            dout_d  = 8'hFF;
            valid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      berr_q   <= 1'b0;
      preq_q   <= 1'b0;
      pwe_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      berr_q   <= berr_d;
      preq_q   <= preq_d;
      pwe_q    <= pwe_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // RAM contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (ram_we_c) mem[Addr] <= DataIn;
  end

endmodule
